// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock-qualification sequencer on the PLL reference clock.
// Optional lock-timeout retry is enabled with `define PLL_RELOCK_RETRY_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// RESET_PLL | pll_rst asserted, counting out the reset pulse
// WAIT_LOCK | pll_rst released, waiting for synchronized lock
// STABLE    | lock seen, counting consecutive locked cycles
// RUN       | lock qualified, core reset released, ready asserted
module pll_reset_sequencer #(
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk_74a,
   input  logic       reset_n,
   input  logic       pll_locked,
   input  logic       sw_reset,
   output logic       pll_rst,
   output logic       core_reset_n,
   output logic       ready,
   output logic [7:0] retry_count
);

   localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
   localparam int CNT_MAX = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] RST_TC   = CNT_W'(PLL_RST_CYCLES - 1);
   // STABLE counts from zero on the cycle after lock was first seen in WAIT_LOCK
   localparam logic [CNT_W-1:0] STB_TC   = CNT_W'(LOCK_STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_FULL = '1;
`ifdef PLL_RELOCK_RETRY_EN
   localparam logic [CNT_W-1:0] TO_TC    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
`endif

   typedef enum logic [1:0] {
      RESET_PLL = 2'd0,
      WAIT_LOCK = 2'd1,
      STABLE    = 2'd2,
      RUN       = 2'd3
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             locked_meta;
   logic             locked_s;

`ifdef PLL_RELOCK_RETRY_EN
   logic [7:0]       retry_q;
   assign retry_count = retry_q;
`else
   assign retry_count = 8'd0;
`endif

   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         locked_meta <= 1'b0;
         locked_s    <= 1'b0;
      end else begin
         locked_meta <= pll_locked;
         locked_s    <= locked_meta;
      end
   end

   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         state        <= RESET_PLL;
         cnt          <= '0;
         pll_rst      <= 1'b1;
         core_reset_n <= 1'b0;
         ready        <= 1'b0;
`ifdef PLL_RELOCK_RETRY_EN
         retry_q      <= 8'd0;
`endif
      end else if (sw_reset) begin
         state        <= RESET_PLL;
         cnt          <= '0;
         pll_rst      <= 1'b1;
         core_reset_n <= 1'b0;
         ready        <= 1'b0;
      end else begin
         case (state)
            RESET_PLL: begin
               if (cnt == RST_TC) begin
                  state   <= WAIT_LOCK;
                  cnt     <= '0;
                  pll_rst <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            WAIT_LOCK: begin
               if (locked_s) begin
                  state <= STABLE;
                  cnt   <= '0;
`ifdef PLL_RELOCK_RETRY_EN
               end else if (cnt == TO_TC) begin
                  state   <= RESET_PLL;
                  cnt     <= '0;
                  pll_rst <= 1'b1;
                  if (retry_q != 8'hFF) retry_q <= retry_q + 8'd1;
`endif
               end else if (cnt != CNT_FULL) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            STABLE: begin
               if (!locked_s) begin
                  state <= WAIT_LOCK;
                  cnt   <= '0;
               end else if (cnt == STB_TC) begin
                  state        <= RUN;
                  core_reset_n <= 1'b1;
                  ready        <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               if (!locked_s) begin
                  state        <= RESET_PLL;
                  cnt          <= '0;
                  pll_rst      <= 1'b1;
                  core_reset_n <= 1'b0;
                  ready        <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed pins plus randomized lock/sw_reset/reset
// traffic compared every cycle against a phase/streak model of the sequencer.
module tb_pll_reset_sequencer;

   localparam int P = 4;
   localparam int L = 8;
   localparam int T = 32;

   logic       clk_74a    = 1'b0;
   logic       reset_n    = 1'b1;
   logic       pll_locked = 1'b0;
   logic       sw_reset   = 1'b0;
   logic       pll_rst;
   logic       core_reset_n;
   logic       ready;
   logic [7:0] retry_count;

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_on  = 1'b0;

   pll_reset_sequencer #(
      .PLL_RST_CYCLES     (P),
      .LOCK_STABLE_CYCLES (L),
      .LOCK_TIMEOUT_CYCLES(T)
   ) dut (
      .clk_74a     (clk_74a),
      .reset_n     (reset_n),
      .pll_locked  (pll_locked),
      .sw_reset    (sw_reset),
      .pll_rst     (pll_rst),
      .core_reset_n(core_reset_n),
      .ready       (ready),
      .retry_count (retry_count)
   );

   always #5 clk_74a = ~clk_74a;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Model: mode 0 = pulse in progress, 1 = qualifying lock, 2 = running.
   // Lock is qualified once L+2 consecutive synchronized-high cycles are seen
   // while qualifying; the lock-low timeout only counts uninterrupted low cycles.
   int m_mode   = 0;
   int m_left   = P;
   int m_streak = 0;
   int m_low    = 0;
   int m_retry  = 0;
   bit m_s1     = 1'b0;
   bit m_s2     = 1'b0;
   bit m_ls     = 1'b0;

   task automatic m_pulse();
      m_mode = 0;
      m_left = P;
   endtask

   always @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         m_pulse();
         m_s1    = 1'b0;
         m_s2    = 1'b0;
         m_retry = 0;
      end else begin
         m_ls = m_s2;
         m_s2 = m_s1;
         m_s1 = pll_locked;
         if (sw_reset) begin
            m_pulse();
         end else if (m_mode == 0) begin
            m_left--;
            if (m_left == 0) begin
               m_mode   = 1;
               m_streak = 0;
               m_low    = 0;
            end
         end else if (m_mode == 1) begin
            if (m_ls) begin
               m_streak++;
               if (m_streak == L + 2) m_mode = 2;
            end else if (m_streak > 0) begin
               m_streak = 0;
               m_low    = 0;
            end else begin
`ifdef PLL_RELOCK_RETRY_EN
               if (m_low == T - 1) begin
                  m_pulse();
                  if (m_retry < 255) m_retry++;
               end else
`endif
               m_low++;
            end
         end else begin
            if (!m_ls) m_pulse();
         end
      end
   end

   always @(negedge clk_74a) begin
      if (cmp_on) begin
         check("model_pll_rst", pll_rst, (m_mode == 0));
         check("model_core_reset_n", core_reset_n, (m_mode == 2));
         check("model_ready", ready, (m_mode == 2));
         check("model_retry_count", retry_count, m_retry);
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk_74a);
   endtask

   // Number of consecutive sampled cycles with pll_rst high, starting now.
   task automatic count_pll_rst(output int c);
      c = 0;
      while (c < 100 && pll_rst === 1'b1) begin
         c++;
         @(negedge clk_74a);
      end
   endtask

   task automatic edges_until_core(input logic v, output int n);
      n = 0;
      while (n < 200) begin
         @(posedge clk_74a);
         n++;
         @(negedge clk_74a);
         if (core_reset_n === v) break;
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk_74a);
      #2 reset_n = 1'b0;
      @(negedge clk_74a);
      #2 reset_n = 1'b1;
   endtask

   initial begin
      int c;
      int n;
      int pulses;
      logic prev;

      #1 reset_n = 1'b0;
      pll_locked = 1'b1;
      #2 cmp_on = 1'b1;
      cycles(3);
      check("reset_pll_rst", pll_rst, 1);
      check("reset_core_reset_n", core_reset_n, 0);
      check("reset_ready", ready, 0);
      check("reset_retry_count", retry_count, 0);

      // Power-up with lock already present
      reset_n = 1'b1;
      #1 count_pll_rst(c);
      check("powerup_pll_rst_len", c, 4);
      edges_until_core(1'b1, n);
      check("powerup_wait_to_run_edges", n, 10);
      check("powerup_ready", ready, 1);

      // Lock loss in RUN for three samples
      cycles(5);
      pll_locked = 1'b0;
      n = 0;
      while (n < 50) begin
         @(posedge clk_74a);
         n++;
         @(negedge clk_74a);
         if (n == 3) pll_locked = 1'b1;
         if (core_reset_n === 1'b0) break;
      end
      check("lockloss_fall_edges", n, 3);
      check("lockloss_ready", ready, 0);
      count_pll_rst(c);
      check("lockloss_pll_rst_len", c, 4);
      edges_until_core(1'b1, n);
      check("lockloss_relock_edges", n, 10);

      // sw_reset together with falling lock
      cycles(3);
      sw_reset   = 1'b1;
      pll_locked = 1'b0;
      @(negedge clk_74a);
      sw_reset = 1'b0;
      check("swreset_core_reset_n", core_reset_n, 0);
      check("swreset_ready", ready, 0);
      count_pll_rst(c);
      check("swreset_pll_rst_len", c, 4);
      cycles(6);
      check("swreset_single_pulse", pll_rst, 0);

      // Lock glitch while qualifying: 5 high, 1 low, then high
      pll_locked = 1'b1;
      n = 0;
      while (n < 100) begin
         @(posedge clk_74a);
         n++;
         @(negedge clk_74a);
         if (n == 5) pll_locked = 1'b0;
         if (n == 6) pll_locked = 1'b1;
         if (core_reset_n === 1'b1) break;
      end
      check("glitch_rise_edges", n, 18);

      // Asynchronous reset mid-STABLE and in RUN
      sw_reset = 1'b1;
      @(negedge clk_74a);
      sw_reset = 1'b0;
      count_pll_rst(c);
      cycles(3);
      #2 reset_n = 1'b0;
      #1;
      check("async_stable_pll_rst", pll_rst, 1);
      check("async_stable_core_reset_n", core_reset_n, 0);
      check("async_stable_ready", ready, 0);
      @(negedge clk_74a);
      #2 reset_n = 1'b1;
      edges_until_core(1'b1, n);
      check("async_run_reached", core_reset_n, 1);
      #2 reset_n = 1'b0;
      #1;
      check("async_run_core_reset_n", core_reset_n, 0);
      check("async_run_ready", ready, 0);
      check("async_run_pll_rst", pll_rst, 1);

      // Lock never arrives
      pll_locked = 1'b0;
      @(negedge clk_74a);
      #2 reset_n = 1'b1;
      pulses = 0;
      prev   = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_74a);
         if (pll_rst === 1'b1 && prev !== 1'b1) pulses++;
         prev = pll_rst;
      end
`ifdef PLL_RELOCK_RETRY_EN
      check("nolock_pulses", pulses, 6);
      check("nolock_retry_count", retry_count, 5);
      cycles(9200);
      check("nolock_retry_saturated", retry_count, 255);
`else
      check("nolock_pulses", pulses, 1);
      check("nolock_retry_count", retry_count, 0);
`endif

      // Randomized lock, sw_reset and reset traffic
      pulse_reset();
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk_74a);
         if (pll_locked) begin
            if ($urandom_range(39, 0) == 0) pll_locked = 1'b0;
         end else begin
            if ($urandom_range(3, 0) == 0) pll_locked = 1'b1;
         end
         sw_reset = ($urandom_range(99, 0) == 0);
         if ($urandom_range(599, 0) == 0) begin
            sw_reset = 1'b0;
            pulse_reset();
         end
      end
      sw_reset = 1'b0;
      cycles(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
